// File: rtl/key_pkg.sv
// Shared definitions for the pushbutton reader: channel FSM states, width helper
// and default timing for a 50 MHz sys_clk.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } key_fsm_e;

    localparam int DB_CYCLES_50M   = 1_000_000;   // 20 ms
    localparam int LONG_CYCLES_50M = 50_000_000;  // 1 s

    // Bits needed to hold 0..v-1; never less than 1.
    function automatic int clog2_w(input int v);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, hold counter and
// registered press/release/long-press pulses. The FSM state is the `state` signal.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_50M,
    parameter int LONG_CYCLES = LONG_CYCLES_50M
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int DBW = clog2_w(DB_CYCLES);
    localparam int HW  = clog2_w(LONG_CYCLES);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic [1:0]     sync_q;
    logic           ks;
    key_fsm_e       state, state_d;
    logic [DBW-1:0] db_cnt, db_cnt_d;
    logic [HW-1:0]  hold_cnt, hold_cnt_d;
    logic           long_done, long_done_d;
    logic           level_d, press_d, release_d, long_d;

    // Flops reset to 1 so a reset never looks like a press edge.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], key_n};
    end

    assign ks = ~sync_q[1];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            long_done   <= 1'b0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            state       <= state_d;
            db_cnt      <= db_cnt_d;
            hold_cnt    <= hold_cnt_d;
            long_done   <= long_done_d;
            key_state   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
            key_long    <= long_d;
        end
    end

    always_comb begin
        state_d     = state;
        db_cnt_d    = db_cnt;
        hold_cnt_d  = hold_cnt;
        long_done_d = long_done;
        level_d     = key_state;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        case (state)
            IDLE: begin
                level_d  = 1'b0;
                db_cnt_d = '0;
                if (ks) begin
                    state_d  = DB_PRESS;
                    db_cnt_d = DBW'(1);
                end
            end
            DB_PRESS: begin
                if (!ks) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_d     = PRESSED;
                    db_cnt_d    = '0;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                    press_d     = 1'b1;
                    level_d     = 1'b1;
                end else begin
                    db_cnt_d = db_cnt + DBW'(1);
                end
            end
            PRESSED: begin
                // Saturating hold count: long_done keeps the pulse to one per press.
                if (hold_cnt != HOLD_LAST) hold_cnt_d = hold_cnt + HW'(1);
                if (hold_cnt == HOLD_LAST && !long_done) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end
                if (!ks) begin
                    state_d  = DB_RELEASE;
                    db_cnt_d = DBW'(1);
                end
            end
            DB_RELEASE: begin
                if (ks) begin
                    state_d  = PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_d   = IDLE;
                    db_cnt_d  = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    db_cnt_d = db_cnt + DBW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/key_event_detect.sv
// KEY_NUM independent debounced key channels with press, release and
// long-press event pulses for application logic in the sys_clk domain.
module key_event_detect
    import key_pkg::*;
#(
    parameter int KEY_NUM     = 4,
    parameter int DB_CYCLES   = DB_CYCLES_50M,
    parameter int LONG_CYCLES = LONG_CYCLES_50M
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_n,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_debounce_ch #(
            .DB_CYCLES  (DB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES)
        ) u_ch (
            .sys_clk    (sys_clk),
            .rst_n      (rst_n),
            .key_n      (key_n[i]),
            .key_state  (key_state[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i])
        );
    end

endmodule
